// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock frequency/liveness monitor.
package clk_mon_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_EVAL    = 2'd3
  } mon_state_e;

  // Depth of the mon_clk toggle synchroniser into clk_c1.
  localparam int SYNC_STAGES = 3;

endpackage

// File: rtl/clk_mon_toggle_sync.sv
// Captures mon_clk rising edges as a toggle, synchronises the toggle into
// clk_c1 and emits a one-cycle pulse per captured edge. The scheme is only
// valid while mon_clk is at most 2/3 of clk_c1, so consecutive toggles are
// never merged by the synchroniser.
module clk_mon_toggle_sync
  import clk_mon_pkg::*;
(
  input  logic clk_c1,
  input  logic rst_n,
  input  logic mon_clk_i,
  output logic mon_edge_o
);

  logic                   tog_q;
  logic [SYNC_STAGES-1:0] sync_q;

  // Invert on every mon_clk rising edge; the level change carries the event.
  always_ff @(posedge mon_clk_i or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= ~tog_q;
  end

  // Shift the toggle level into the clk_c1 domain.
  always_ff @(posedge clk_c1 or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], tog_q};
  end

  // A change between the two oldest stages marks one mon_clk edge.
  assign mon_edge_o = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/clk_mon_freq_check.sv
// Frequency/liveness monitor: counts mon_clk edges over a fixed clk_c1
// window, compares against EXP_EDGES +/- TOL and maintains clk_ok/fault,
// pulsing rerst_req on a pass->fail transition.
// Optional build macro CLK_MON_STICKY_EN: fault latches until rst_n,
// clk_ok cannot re-qualify after a fault, rerst_req fires at most once.
module clk_mon_freq_check
  import clk_mon_pkg::*;
#(
  parameter int WIN_CYCLES   = 1000,
  parameter int EXP_EDGES    = 240,
  parameter int TOL          = 4,
  parameter int CNT_W        = 16,
  parameter int GOOD_WINDOWS = 2
) (
  input  logic             clk_c1,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             enable,
  output logic             clk_ok,
  output logic             fault,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             rerst_req
);

  localparam int WIN_W  = $clog2(WIN_CYCLES + 1);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  // Lower bound clamps at zero so a large TOL cannot underflow.
  localparam int LO_INT = (EXP_EDGES > TOL) ? (EXP_EDGES - TOL) : 0;
  localparam logic [CNT_W:0]    LO_BOUND  = (CNT_W+1)'(LO_INT);
  localparam logic [CNT_W:0]    HI_BOUND  = (CNT_W+1)'(EXP_EDGES + TOL);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(GOOD_WINDOWS);

  mon_state_e        state_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [GOOD_W-1:0] good_cnt_q;
  logic [GOOD_W-1:0] good_cnt_d;
  logic              last_pass_q;
  logic              clk_ok_q;
  logic              fault_q;
  logic [CNT_W-1:0]  meas_count_q;
  logic              meas_valid_q;
  logic              rerst_q;
  logic              mon_edge;
  logic              pass;
`ifdef CLK_MON_STICKY_EN
  logic              rerst_done_q;
`endif

  clk_mon_toggle_sync u_toggle_sync (
    .clk_c1     (clk_c1),
    .rst_n      (rst_n),
    .mon_clk_i  (mon_clk),
    .mon_edge_o (mon_edge)
  );

  // Window verdict, evaluated one bit wider than the counter.
  assign pass = ({1'b0, edge_cnt_q} >= LO_BOUND) && ({1'b0, edge_cnt_q} <= HI_BOUND);

  // Consecutive-pass count after a passing window, saturating at GOOD_WINDOWS.
  assign good_cnt_d = (good_cnt_q == GOOD_FULL) ? good_cnt_q : good_cnt_q + 1'b1;

  // Sequencer: arm, measure a fixed window, evaluate and publish flags.
  always_ff @(posedge clk_c1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      good_cnt_q   <= '0;
      last_pass_q  <= 1'b0;
      clk_ok_q     <= 1'b0;
      fault_q      <= 1'b0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      rerst_q      <= 1'b0;
`ifdef CLK_MON_STICKY_EN
      rerst_done_q <= 1'b0;
`endif
    end else begin
      meas_valid_q <= 1'b0;
      rerst_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_ARM;
        end
        ST_ARM: begin
          win_cnt_q  <= '0;
          edge_cnt_q <= '0;
          state_q    <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (!enable) begin
            // Abandon the partial window; published results stay untouched.
            state_q <= ST_IDLE;
          end else begin
            if (mon_edge && (edge_cnt_q != CNT_MAX)) edge_cnt_q <= edge_cnt_q + 1'b1;
            if (win_cnt_q == WIN_LAST) state_q   <= ST_EVAL;
            else                       win_cnt_q <= win_cnt_q + 1'b1;
          end
        end
        ST_EVAL: begin
          meas_count_q <= edge_cnt_q;
          meas_valid_q <= 1'b1;
          win_cnt_q    <= '0;
          edge_cnt_q   <= '0;
          last_pass_q  <= pass;
          if (pass) begin
            good_cnt_q <= good_cnt_d;
`ifdef CLK_MON_STICKY_EN
            clk_ok_q   <= (good_cnt_d == GOOD_FULL) && !fault_q;
`else
            clk_ok_q   <= (good_cnt_d == GOOD_FULL);
            fault_q    <= 1'b0;
`endif
          end else begin
            good_cnt_q <= '0;
            clk_ok_q   <= 1'b0;
            fault_q    <= 1'b1;
`ifdef CLK_MON_STICKY_EN
            rerst_q    <= (last_pass_q || clk_ok_q) && !rerst_done_q;
            if (last_pass_q || clk_ok_q) rerst_done_q <= 1'b1;
`else
            rerst_q    <= last_pass_q || clk_ok_q;
`endif
          end
          state_q <= enable ? ST_MEASURE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clk_ok     = clk_ok_q;
  assign fault      = fault_q;
  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign rerst_req  = rerst_q;

endmodule

// File: tb/tb_clk_mon_freq_check.sv
// Testbench for clk_mon_freq_check: directed scenarios with literal
// expectations, then randomized mon_clk frequencies, enable drops and a
// mid-run reset, all checked each cycle against a window-sum model.
`timescale 1ps/1ps
module tb_clk_mon_freq_check;

    localparam int WIN   = 1000;
    localparam int EXP   = 240;
    localparam int TOL   = 4;
    localparam int CNT_W = 16;
    localparam int GOODW = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARM   = 1;
    localparam int PH_OPEN  = 2;
    localparam int PH_CLOSE = 3;

    logic             clk_c1 = 1'b0;
    logic             rst_n;
    logic             mon_clk;
    logic             enable;
    logic             clk_ok;
    logic             fault;
    logic [CNT_W-1:0] meas_count;
    logic             meas_valid;
    logic             rerst_req;

    int errors = 0;
    int checks = 0;

    clk_mon_freq_check #(
        .WIN_CYCLES  (WIN),
        .EXP_EDGES   (EXP),
        .TOL         (TOL),
        .CNT_W       (CNT_W),
        .GOOD_WINDOWS(GOODW)
    ) dut (
        .clk_c1    (clk_c1),
        .rst_n     (rst_n),
        .mon_clk   (mon_clk),
        .enable    (enable),
        .clk_ok    (clk_ok),
        .fault     (fault),
        .meas_count(meas_count),
        .meas_valid(meas_valid),
        .rerst_req (rerst_req)
    );

    // 100 MHz reference: posedges at 5000 + 10000k ps (always even).
    always #5000 clk_c1 = ~clk_c1;

    // Clock under test: edges land on odd ps so they never tie with clk_c1.
    int mon_half = 0;
    initial begin
        mon_clk = 1'b0;
        #1;
        forever begin
            if (mon_half == 0) begin
                mon_clk = 1'b0;
                #1000;
            end else begin
                mon_clk = ~mon_clk;
                #(mon_half);
            end
        end
    end

    int unsigned mon_edges = 0;
    always @(posedge mon_clk) if (rst_n) mon_edges++;

    int rerst_cnt = 0;
    always @(negedge clk_c1) if (rerst_req) rerst_cnt++;

    // Reference model: edges are delayed two reference cycles by the
    // synchroniser; a window is the sum of 1000 consecutive delayed edge counts.
    int unsigned last_seen = 0;
    int cyc = 0;
    int d1 = 0, d2 = 0;
    int ph = PH_IDLE, left = 0, good = 0, m_count = 0;
    bit prev_pass = 0, m_ok = 0, m_fault = 0, m_valid = 0, m_rerst = 0;
`ifdef CLK_MON_STICKY_EN
    bit rerst_used = 0;
`endif
    int win_q[$];

    always @(posedge clk_c1) begin : model
        int n, e, sum;
        bit pass;
        cyc++;
        n = int'(mon_edges - last_seen);
        last_seen = mon_edges;
        e = d2; d2 = d1; d1 = n;
        m_valid = 1'b0;
        m_rerst = 1'b0;
        if (!rst_n) begin
            ph = PH_IDLE; left = 0; good = 0; prev_pass = 0;
            m_ok = 0; m_fault = 0; m_count = 0; d1 = 0; d2 = 0;
`ifdef CLK_MON_STICKY_EN
            rerst_used = 0;
`endif
            win_q.delete();
        end else begin
            case (ph)
                PH_IDLE: if (enable) ph = PH_ARM;
                PH_ARM: begin
                    win_q.delete(); left = WIN; ph = PH_OPEN;
                end
                PH_OPEN: begin
                    if (!enable) ph = PH_IDLE;
                    else begin
                        win_q.push_back(e);
                        left--;
                        if (left == 0) ph = PH_CLOSE;
                    end
                end
                default: begin
                    sum = 0;
                    foreach (win_q[i]) sum += win_q[i];
                    pass = (sum >= EXP - TOL) && (sum <= EXP + TOL);
                    m_count = sum;
                    m_valid = 1'b1;
                    if (pass) begin
                        good = (good < GOODW) ? good + 1 : GOODW;
`ifdef CLK_MON_STICKY_EN
                        m_ok = (good == GOODW) && !m_fault;
`else
                        m_ok = (good == GOODW);
                        m_fault = 1'b0;
`endif
                    end else begin
                        m_rerst = prev_pass || m_ok;
`ifdef CLK_MON_STICKY_EN
                        m_rerst = m_rerst && !rerst_used;
                        if (m_rerst) rerst_used = 1'b1;
`endif
                        good = 0; m_ok = 1'b0; m_fault = 1'b1;
                    end
                    prev_pass = pass;
                    win_q.delete();
                    left = WIN;
                    ph = enable ? PH_OPEN : PH_IDLE;
                end
            endcase
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    task automatic wait_valid(input int budget, output int at_cyc);
        bit seen;
        seen = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_c1);
            if (meas_valid) begin
                seen = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!seen) chk("meas_valid_timeout", 0, 1);
    endtask

    initial begin
        int v0, v1, c_en, nval, run;
        rst_n  = 1'b0;
        enable = 1'b0;

        // Per-cycle comparison against the model, plus one line per result.
        fork
            forever begin
                @(negedge clk_c1);
                chk("clk_ok", clk_ok, m_ok);
                chk("fault", fault, m_fault);
                chk("meas_count", meas_count, m_count);
                chk("meas_valid", meas_valid, m_valid);
                chk("rerst_req", rerst_req, m_rerst);
                if (meas_valid)
                    $display("window cycle=%0d count=%0d clk_ok=%0d fault=%0d rerst_req=%0d",
                             cyc, meas_count, clk_ok, fault, rerst_req);
            end
        join_none

        repeat (4) @(negedge clk_c1);
        chk("reset_clk_ok", clk_ok, 0);
        chk("reset_fault", fault, 0);
        chk("reset_meas_count", meas_count, 0);
        chk("reset_meas_valid", meas_valid, 0);
        chk("reset_rerst_req", rerst_req, 0);
        #2000 rst_n = 1'b1;

        // ~24 MHz: two good windows qualify the clock.
        mon_half = 20834;
        repeat (20) @(negedge clk_c1);
        enable = 1'b1;
        c_en = cyc + 1;
        wait_valid(1100, v0);
        chk("first_valid_latency", v0 - c_en, 1002);
        chk_range("count_24m_w1", meas_count, 239, 241);
        chk("fault_24m_w1", fault, 0);
        chk("clk_ok_24m_w1", clk_ok, 0);
        wait_valid(1100, v1);
        chk("second_valid_latency", v1 - c_en, 2003);
        chk_range("count_24m_w2", meas_count, 239, 241);
        chk("clk_ok_24m_w2", clk_ok, 1);

        // Drop enable mid-window: nothing published, flags hold.
        repeat (499) @(negedge clk_c1);
        enable = 1'b0;
        nval = 0;
        repeat (1100) begin
            @(negedge clk_c1);
            if (meas_valid) nval++;
        end
        chk("valid_while_disabled", nval, 0);
        chk("clk_ok_hold", clk_ok, 1);
        chk("fault_hold", fault, 0);
        chk_range("count_hold", meas_count, 239, 241);
        enable = 1'b1;
        c_en = cyc + 1;
        wait_valid(1100, v0);
        chk("rearm_latency", v0 - c_en, 1002);
        chk("clk_ok_rearm", clk_ok, 1);
        chk("rerst_before_stop", rerst_cnt, 0);

        // Stop mon_clk: one fault, one rerst pulse, then silence.
        mon_half = 0;
        wait_valid(1100, v0);
        chk("fault_stop", fault, 1);
        chk("clk_ok_stop", clk_ok, 0);
        chk("rerst_stop", rerst_req, 1);
        wait_valid(1100, v0);
        chk("count_stopped", meas_count, 0);
        chk("rerst_stopped_w2", rerst_req, 0);
        wait_valid(1100, v0);
        chk("rerst_stopped_w3", rerst_req, 0);

        // 27 MHz: out of tolerance, never qualifies.
        mon_half = 18518;
        wait_valid(1100, v0);
        wait_valid(1100, v0);
        chk_range("count_27m", meas_count, 268, 272);
        chk("fault_27m", fault, 1);
        chk("clk_ok_27m", clk_ok, 0);
        chk("rerst_27m", rerst_req, 0);

        // 24.3 MHz: inside tolerance.
        mon_half = 20576;
        wait_valid(1100, v0);
        wait_valid(1100, v0);
        chk_range("count_24m3", meas_count, 241, 245);
        wait_valid(1100, v0);
`ifdef CLK_MON_STICKY_EN
        chk("fault_24m3_sticky", fault, 1);
        chk("clk_ok_24m3_sticky", clk_ok, 0);
`else
        chk("fault_24m3", fault, 0);
        chk("clk_ok_24m3", clk_ok, 1);
`endif
        repeat (2) @(negedge clk_c1);
        chk("rerst_total", rerst_cnt, 1);

        // Randomized frequencies, enable drops and one asynchronous reset.
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 9))
                0:       mon_half = 0;
                1:       mon_half = 2 * $urandom_range(7000, 9000);
                default: mon_half = 2 * $urandom_range(10150, 10700);
            endcase
            run = $urandom_range(300, 2200);
            repeat (run) @(negedge clk_c1);
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 40)) @(negedge clk_c1);
                enable = 1'b1;
            end
            if (it == 8) begin
                @(negedge clk_c1);
                #2000 rst_n = 1'b0;
                @(negedge clk_c1);
                chk("midreset_clk_ok", clk_ok, 0);
                chk("midreset_fault", fault, 0);
                chk("midreset_meas_count", meas_count, 0);
                chk("midreset_meas_valid", meas_valid, 0);
                chk("midreset_rerst_req", rerst_req, 0);
                repeat (3) @(negedge clk_c1);
                #2000 rst_n = 1'b1;
            end
        end
        repeat (5) @(negedge clk_c1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
